// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg: shared types and constants for the encounter scheduler.
//   sched_state_t     scheduler FSM state (IDLE, WAIT)
//   DEF_*             default tick constants for the scheduler parameters
//   lfsr_taps(width)  Fibonacci LFSR feedback tap mask for a given width
//                     (bit i set means register bit i feeds the XOR)
package enc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sched_state_t;

    localparam int DEF_BASE_TICKS = 100000000;
    localparam int DEF_STEP_TICKS = 60000000;
    localparam int DEF_SPD_TICKS  = 5000000;
    localparam int DEF_MIN_TICKS  = 20000000;

    // Maximal-length tap sets. Widths outside the table fall back to the
    // two top bits, which shifts but is not guaranteed maximal length.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0E08;
            13:      lfsr_taps = 32'h0000_1C80;
            14:      lfsr_taps = 32'h0000_3802;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = 32'h0000_B400;
            17:      lfsr_taps = 32'h0001_2000;
            18:      lfsr_taps = 32'h0002_0400;
            19:      lfsr_taps = 32'h0007_2000;
            20:      lfsr_taps = 32'h0009_0000;
            24:      lfsr_taps = 32'h00E1_0000;
            32:      lfsr_taps = 32'hA300_0000;
            default: lfsr_taps = (32'd1 << (width - 1)) | (32'd1 << (width - 2));
        endcase
    endfunction

endpackage

// File: rtl/enc_lfsr.sv
// enc_lfsr: free-running Fibonacci LFSR, shifts left on every clock.
// Parameters: LFSR_W (4..32), SEED (reset value; an all-zero seed is
// replaced by 1 so the register cannot lock up).
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset, reloads the seed
//   q      out  current LFSR contents
module enc_lfsr
    import enc_sched_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    localparam logic [31:0]       TAPS     = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAP_MASK = TAPS[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_NZ  = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic feedback;

    assign feedback = ^(q & TAP_MASK);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED_NZ;
        end else begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/enc_scheduler.sv
// enc_scheduler: issues a one-hot "spawn encounter" lane select at
// pseudo-random intervals drawn from an internal LFSR.
// Parameters: NUM_CH lanes, CNT_W counter width, BASE/STEP/SPD/MIN_TICKS
// interval shaping, SPD_W speed width, LFSR_W/SEED for the random source.
// Ports:
//   clock    in          system clock
//   reset    in          synchronous active-high reset
//   enable   in          1 = run, 0 = pause (counter and outputs frozen)
//   mode     in          0 = round-robin lanes, 1 = random lanes
//   speed    in  SPD_W   difficulty level, shortens the interval
//   enc_out  out NUM_CH  one-hot lane of the latest issue, held until the next
//   enc_stb  out         one-cycle pulse on every issue
// Optional build macro: ENC_SCHED_NO_REPEAT_EN -- in random mode a lane that
// equals the previous issue's lane is bumped to the next lane.
//
// Handshake: enc_stb is a fire-and-forget strobe with no ready/back-pressure;
// the consumer must take enc_out on every cycle enc_stb is high.
module enc_scheduler
    import enc_sched_pkg::*;
#(
    parameter int                NUM_CH     = 3,
    parameter int                CNT_W      = 31,
    parameter int                BASE_TICKS = DEF_BASE_TICKS,
    parameter int                STEP_TICKS = DEF_STEP_TICKS,
    parameter int                SPD_W      = 4,
    parameter int                SPD_TICKS  = DEF_SPD_TICKS,
    parameter int                MIN_TICKS  = DEF_MIN_TICKS,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [SPD_W-1:0]  speed,
    output logic [NUM_CH-1:0] enc_out,
    output logic              enc_stb
);

    localparam int SEL_W = $clog2(NUM_CH);
    // Wide enough that the speed reduction can drive the sum negative
    // without wrapping, so the floor comparison stays honest.
    localparam int RAW_W = CNT_W + SPD_W + 2;

    typedef logic signed [RAW_W-1:0] raw_t;

    localparam raw_t BASE_S = raw_t'(BASE_TICKS);
    localparam raw_t STEP_S = raw_t'(STEP_TICKS);
    localparam raw_t SPD_S  = raw_t'(SPD_TICKS);
    localparam raw_t MIN_S  = raw_t'(MIN_TICKS);

    if (NUM_CH < 2) begin : g_chk_ch
        $error("enc_scheduler: NUM_CH must be at least 2");
    end
    if (LFSR_W < 4 || LFSR_W > 32) begin : g_chk_lfsr
        $error("enc_scheduler: LFSR_W must be within 4..32");
    end
    if ((64'(BASE_TICKS) + 64'(3) * 64'(STEP_TICKS)) >= (64'(1) << CNT_W)) begin : g_chk_cnt
        $error("enc_scheduler: BASE_TICKS + 3*STEP_TICKS does not fit in CNT_W bits");
    end

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(NUM_CH - 1)) ? '0 : v + 1'b1;
    endfunction

    sched_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  rr;
`ifdef ENC_SCHED_NO_REPEAT_EN
    logic [SEL_W-1:0]  last;
    logic              issued;   // at least one issue since reset
`endif

    logic [LFSR_W-1:0] lfsr_q;
    logic [1:0]        r_unit;
    raw_t              raw;
    logic [CNT_W-1:0]  interval;
    logic [SEL_W-1:0]  sel_rand;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  sel_next;
    logic              issue;

    enc_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .q      (lfsr_q)
    );

    always_comb begin
        r_unit   = lfsr_q[1:0];
        raw      = BASE_S + STEP_S * raw_t'(r_unit) - SPD_S * raw_t'(speed);
        interval = (raw < MIN_S) ? CNT_W'(MIN_TICKS) : raw[CNT_W-1:0];

        sel_rand = SEL_W'(32'(lfsr_q[LFSR_W-1:2]) % 32'(NUM_CH));
        sel      = rr;
        if (mode) begin
            sel = sel_rand;
`ifdef ENC_SCHED_NO_REPEAT_EN
            if (issued && (sel_rand == last)) begin
                sel = wrap_inc(sel_rand);
            end
`endif
        end
        sel_next = wrap_inc(sel);

        // IDLE issues on the first enabled edge; WAIT issues once the
        // countdown has reached zero. A paused edge never issues.
        issue = enable && ((state == IDLE) || (cnt == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rr      <= '0;
            enc_out <= '0;
            enc_stb <= 1'b0;
`ifdef ENC_SCHED_NO_REPEAT_EN
            last    <= '0;
            issued  <= 1'b0;
`endif
        end else begin
            enc_stb <= 1'b0;
            if (issue) begin
                state   <= WAIT;
                enc_out <= NUM_CH'(1) << sel;
                enc_stb <= 1'b1;
                cnt     <= interval;
                rr      <= sel_next;
`ifdef ENC_SCHED_NO_REPEAT_EN
                last    <= sel;
                issued  <= 1'b1;
`endif
            end else if (enable && (state == WAIT)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enc_scheduler.sv
// tb_enc_scheduler: randomized self-checking bench for enc_scheduler with a
// behavioural reference model (issue timing by counting enabled edges since
// the last issue, lane choice and interval from the textual rules).
module tb_enc_scheduler;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int BASE   = 4;
    localparam int STEP   = 2;
    localparam int SPD    = 1;
    localparam int MINT   = 2;
    localparam int SPD_W  = 4;
    localparam int LFSR_W = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              mode;
    logic [SPD_W-1:0]  speed;
    logic [NUM_CH-1:0] enc_out;
    logic              enc_stb;

    // ---------------- clock / reset block ----------------
    always #5 clock = ~clock;

    enc_scheduler #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .BASE_TICKS (BASE),
        .STEP_TICKS (STEP),
        .SPD_W      (SPD_W),
        .SPD_TICKS  (SPD),
        .MIN_TICKS  (MINT),
        .LFSR_W     (LFSR_W),
        .SEED       (SEED)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .speed   (speed),
        .enc_out (enc_out),
        .enc_stb (enc_stb)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [15:0]       m_lfsr;
    int                m_since;
    int                m_interval;
    int                m_rr;
    int                m_last;
    bit                m_started;
    logic              m_stb;
    logic [NUM_CH-1:0] m_out;

    logic [NUM_CH-1:0] exp_q[$];
    int                mdl_int[$];
    int                mdl_lane[$];
    int                obs_cyc[$];
    int                obs_out[$];
    int                stb_count = 0;
    int                cyc = 0;

    always @(posedge clock) begin : model
        logic [15:0] l;
        int          lane;
        int          r;
        int          raw;
        bit          fire;
        cyc++;
        l    = m_lfsr;
        fire = 1'b0;
        if (reset) begin
            m_lfsr    = SEED;
            m_stb     = 1'b0;
            m_out     = '0;
            m_started = 1'b0;
            m_since   = 0;
            m_rr      = 0;
            m_last    = 0;
            exp_q.delete();
        end else begin
            if (enable) begin
                m_since++;
                fire = !m_started || (m_since == m_interval + 1);
            end
            if (fire) begin
                if (mode) lane = int'(l[15:2]) % NUM_CH;
                else      lane = m_rr;
`ifdef ENC_SCHED_NO_REPEAT_EN
                if (mode && m_started && lane == m_last) lane = (lane + 1) % NUM_CH;
`endif
                r          = int'(l[1:0]);
                raw        = BASE + STEP * r - SPD * int'(speed);
                m_interval = (raw < MINT) ? MINT : raw;
                m_out      = NUM_CH'(1) << lane;
                m_rr       = (lane + 1) % NUM_CH;
                m_last     = lane;
                m_started  = 1'b1;
                m_since    = 0;
                exp_q.push_back(m_out);
                mdl_int.push_back(m_interval);
                mdl_lane.push_back(int'(m_out));
            end
            m_stb  = fire;
            m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        #1;
        check("stb", 32'(enc_stb), 32'(m_stb));
        check("out", 32'(enc_out), 32'(m_out));
        if (enc_stb === 1'b1) begin
            stb_count++;
            obs_cyc.push_back(cyc);
            obs_out.push_back(int'(enc_out));
            if (exp_q.size() == 0) check("sb_extra", 32'(enc_stb), 32'd0);
            else                   check("sb_lane", 32'(enc_out), 32'(exp_q.pop_front()));
        end
    end

    function automatic int obs_at(input int i);
        return (i >= 0 && i < obs_out.size()) ? obs_out[i] : -1;
    endfunction

    function automatic int gap(input int i);
        return (i >= 1 && i < obs_cyc.size()) ? obs_cyc[i] - obs_cyc[i-1] : -1;
    endfunction

    function automatic int mdl_int_at(input int i);
        return (i >= 0 && i < mdl_int.size()) ? mdl_int[i] : -2;
    endfunction

    function automatic int mdl_lane_at(input int i);
        return (i >= 0 && i < mdl_lane.size()) ? mdl_lane[i] : -2;
    endfunction

    // ---------------- driver tasks ----------------
    // Entered at a negedge; leaves reset released and enable high at a negedge.
    task automatic apply_reset(input int n, input bit chk);
        reset  = 1'b1;
        enable = 1'b0;
        if (chk) begin
            @(posedge clock);
            #1;
            check("rst_out", 32'(enc_out), 32'd0);
            check("rst_stb", 32'(enc_stb), 32'd0);
            @(negedge clock);
            repeat (n - 1) @(negedge clock);
        end else begin
            repeat (n) @(negedge clock);
        end
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int target = stb_count + n;
        int k = 0;
        while (stb_count < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (stb_count < target) check("timeout", 32'(stb_count), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    int t1_exp[4] = '{1, 2, 4, 1};
    int t1_gap[3];

    initial begin : stim
        int b;
        int g;
        int dut_rep;
        int mdl_rep;
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 1'b0;
        speed  = '0;

        // 1: round-robin after reset, spacing 5+2r
        apply_reset(3, 1'b0);
        b = obs_out.size();
        wait_strobes(4, 60);
        for (int i = 0; i < 4; i++) check("t1_lane", obs_at(b + i), t1_exp[i]);
        for (int i = 1; i < 4; i++) begin
            g = gap(b + i);
            t1_gap[i-1] = g;
            check("t1_gap", g, mdl_int_at(b + i - 1) + 1);
            check("t1_rng", 32'(g >= 5 && g <= 11), 32'd1);
        end

        // 2: max speed clamps to the floor -> strobe every MINT+1 cycles
        speed = 4'd15;
        wait_strobes(1, 30);
        b = obs_out.size();
        wait_strobes(3, 30);
        for (int i = 0; i < 3; i++) check("t2_gap", gap(b + i), MINT + 1);

        // 3: ten paused cycles stretch the spacing by ten
        enable = 1'b0;
        repeat (10) @(negedge clock);
        enable = 1'b1;
        wait_strobes(1, 40);
        check("t3_gap", gap(obs_out.size() - 1), MINT + 1 + 10);

        // 5: reset two cycles into WAIT, then the test-1 sequence replays
        mode  = 1'b0;
        speed = '0;
        wait_strobes(1, 30);
        repeat (2) @(negedge clock);
        apply_reset(3, 1'b1);
        b = obs_out.size();
        wait_strobes(4, 60);
        for (int i = 0; i < 4; i++) check("t5_lane", obs_at(b + i), t1_exp[i]);
        for (int i = 1; i < 4; i++) check("t5_gap", gap(b + i), t1_gap[i-1]);

        // 6: mode change mid-interval only affects the following issue
        wait_strobes(1, 30);
        b = obs_out.size() - 1;
        repeat (2) @(negedge clock);
        mode = 1'b1;
        wait_strobes(1, 30);
        check("t6_gap", gap(b + 1), mdl_int_at(b) + 1);
        check("t6_lane", obs_at(b + 1), mdl_lane_at(b + 1));

        // 4: 200 random-mode issues with random speed and pauses
        b = obs_out.size();
        for (int k = 0; k < 200; k++) begin
            speed = SPD_W'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clock);
                enable = 1'b1;
            end
            wait_strobes(1, 60);
        end
        dut_rep = 0;
        mdl_rep = 0;
        for (int i = b + 1; i < obs_out.size(); i++) begin
            if (obs_out[i] == obs_out[i-1]) dut_rep++;
            if (mdl_lane_at(i) == mdl_lane_at(i - 1)) mdl_rep++;
        end
`ifdef ENC_SCHED_NO_REPEAT_EN
        check("t4_norep", dut_rep, 0);
`else
        check("t4_rep", dut_rep, mdl_rep);
`endif

        repeat (2) @(negedge clock);
        check("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
